// File: rtl/dmem_responder_pkg.sv
// Shared types and geometry helpers for the line-burst memory responder.
// Package constants describe the default line geometry; other sizes derive theirs.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int LINE_WORDS_DEFAULT = 4;
  localparam int LINE_OFFSET_BITS   = $clog2(LINE_WORDS_DEFAULT);
  localparam int BEAT_WIDTH         = LINE_OFFSET_BITS;

  function automatic int line_offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  // Wide enough to hold LATENCY itself; never narrower than one bit.
  function automatic int count_width(input int latency);
    return (latency < 2) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-wide storage: combinational read, write committed on the rising edge.
// Contents are never reset; they persist across responder resets.
module mem_word_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 14
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [INDEX_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dmem_responder.sv
// Cache-line memory responder: accepts one line refill or write-back, waits LATENCY
// cycles, then streams LINE_WORDS beats (rsp_ready / wr_valid may stall each beat).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int LINE_WORDS    = LINE_WORDS_DEFAULT,
  parameter int LATENCY       = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_last,
  input  logic                     rsp_ready,
  input  logic                     wr_valid,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_ready,
  output logic                     wr_done
);

  localparam int OFF_BITS = (LINE_WORDS == LINE_WORDS_DEFAULT) ? LINE_OFFSET_BITS
                                                               : line_offset_bits(LINE_WORDS);
  localparam int BEAT_W   = (LINE_WORDS == LINE_WORDS_DEFAULT) ? BEAT_WIDTH
                                                               : line_offset_bits(LINE_WORDS);
  localparam int IDX_W    = ADDRESS_WIDTH - 2;
  localparam int CNT_W    = count_width(LATENCY);

  state_t              state, state_n;
  logic [BEAT_W-1:0]   beat, beat_n;
  logic [CNT_W-1:0]    count, count_n;
  logic [IDX_W-1:0]    base, base_n;
  logic                write_op, write_op_n;
  logic [IDX_W-1:0]    word_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                mem_we;
  logic                last_beat;
  logic                unused_addr_bits;

  // Byte and in-line word offset bits never affect which line is addressed.
  assign unused_addr_bits = ^req_addr[OFF_BITS+1:0];

  // base is line-aligned, so adding the beat never carries out of the line.
  assign word_idx  = base + IDX_W'(beat);
  assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));

  mem_word_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (IDX_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (word_idx),
    .wr_data (wr_data),
    .rd_addr (word_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      beat     <= '0;
      count    <= '0;
      base     <= '0;
      write_op <= 1'b0;
    end else begin
      state    <= state_n;
      beat     <= beat_n;
      count    <= count_n;
      base     <= base_n;
      write_op <= write_op_n;
    end
  end

  always_comb begin
    state_n    = state;
    beat_n     = beat;
    count_n    = count;
    base_n     = base;
    write_op_n = write_op;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_last   = 1'b0;
    wr_ready   = 1'b0;
    wr_done    = 1'b0;
    mem_we     = 1'b0;

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          base_n     = {req_addr[ADDRESS_WIDTH-1:OFF_BITS+2], {OFF_BITS{1'b0}}};
          write_op_n = req_we;
          beat_n     = '0;
          if (LATENCY > 0) begin
            state_n = S_WAIT;
            count_n = CNT_W'(LATENCY);
          end else begin
            state_n = req_we ? S_WRITE : S_READ;
          end
        end
      end

      S_WAIT: begin
        if (count <= CNT_W'(1)) begin
          count_n = '0;
          state_n = write_op ? S_WRITE : S_READ;
        end else begin
          count_n = count - CNT_W'(1);
        end
      end

      S_READ: begin
        rsp_valid = 1'b1;
        rsp_data  = rd_data;
        rsp_last  = last_beat;
        if (rsp_ready) begin
          beat_n = beat + BEAT_W'(1);
          if (last_beat) begin
            state_n = S_IDLE;
          end
        end
      end

      S_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_we = 1'b1;
          beat_n = beat + BEAT_W'(1);
          if (last_beat) begin
            state_n = S_DONE;
          end
        end
      end

      S_DONE: begin
        wr_done = 1'b1;
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
